// File: rtl/radix8_pkg.sv
// Shared types and constants for the radix-8 multiplier scheduler.
// The operand and product widths are fixed by the external datapath.
// The requester id width covers up to 8 requesters.
package radix8_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int ID_W   = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One pipeline tag travels alongside each operation in the datapath.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  // Converts a one-hot grant (zero-extended to 8 bits) into a requester index.
  // An all-zero input returns 0.
  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [7:0] oh);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. The search starts at i_ptr and wraps around.
// The request vector is rotated so that i_ptr sits at bit 0, a fixed-priority
// pick is made, and the one-hot result is rotated back into place.
// i_ptr must be below NREQ.
module rr_arbiter
  import radix8_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant
);

  logic [NREQ-1:0]   w_rot_req;
  logic [NREQ-1:0]   w_rot_gnt;
  logic [2*NREQ-1:0] w_gnt2;
  logic              w_found;

  // Rotate, pick the lowest set bit, then rotate back and fold the halves.
  always_comb begin
    w_rot_req = NREQ'({i_req, i_req} >> i_ptr);
    w_rot_gnt = '0;
    w_found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_rot_req[k] && !w_found) begin
        w_rot_gnt[k] = 1'b1;
        w_found      = 1'b1;
      end
    end
    w_gnt2  = {{NREQ{1'b0}}, w_rot_gnt} << i_ptr;
    o_grant = w_gnt2[NREQ-1:0] | w_gnt2[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/radix8_mul_scheduler.sv
// Shares one pipelined radix-8 multiplier among NREQ requesters.
// A granted operand pair is registered onto mul_a/mul_b and marked with a
// one-cycle mul_en pulse. A tag {valid, id} follows each operation through a
// MUL_LAT-deep shift register. When the tag leaves the register, mul_res is
// captured into rsp_data and rsp_valid is raised for the owning requester.
// flush_req stops new grants and drains the pipeline. flush_done is raised
// once the pipeline is empty.
// Optional build macro: RADIX8_SCHED_STATS_EN adds the grant_cnt output with
// per-requester 16-bit transfer counters.
//
// state | meaning
// RUN   | granting and issuing operations
// DRAIN | no new grants, waiting for in-flight operations to leave
// DONE  | pipeline empty, flush_done high until flush_req drops
module radix8_mul_scheduler
  import radix8_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*OP_W-1:0]   req_a,
  input  logic [NREQ*OP_W-1:0]   req_b,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   flush_req,
  output logic                   flush_done,
  output logic                   mul_en,
  output logic [OP_W-1:0]        mul_a,
  output logic [OP_W-1:0]        mul_b,
  input  logic [PROD_W-1:0]      mul_res,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [PROD_W-1:0]      rsp_data,
`ifdef RADIX8_SCHED_STATS_EN
  output logic                   busy,
  output logic [NREQ*16-1:0]     grant_cnt
`else
  output logic                   busy
`endif
);

  state_t          r_state;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_issue_id;
  tag_t            r_tag [MUL_LAT];

  logic [NREQ-1:0] w_grant;
  logic            w_xfer;
  logic [ID_W-1:0] w_gnt_id;
  logic [ID_W-1:0] w_ptr_nxt;
  logic [OP_W-1:0] w_sel_a;
  logic [OP_W-1:0] w_sel_b;
  logic            w_tags_busy;
  tag_t            w_tail;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // Grants go out only in RUN. A flush request masks the grant in the same
  // cycle, so nothing is accepted on the cycle the flush starts.
  assign req_ready = (r_state == ST_RUN && !flush_req) ? w_grant : '0;
  assign w_xfer    = |(req_valid & req_ready);
  assign w_tail    = r_tag[MUL_LAT-1];
  assign busy      = mul_en | w_tags_busy;

  // Operand select, granted id, next pointer and tag occupancy.
  always_comb begin
    w_sel_a     = '0;
    w_sel_b     = '0;
    w_tags_busy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        w_sel_a = req_a[OP_W*i +: OP_W];
        w_sel_b = req_b[OP_W*i +: OP_W];
      end
    end
    w_gnt_id  = onehot_to_idx(8'(req_ready));
    w_ptr_nxt = (w_gnt_id == ID_W'(NREQ-1)) ? '0 : w_gnt_id + ID_W'(1);
    for (int k = 0; k < MUL_LAT; k++) begin
      w_tags_busy = w_tags_busy | r_tag[k].valid;
    end
  end

  // Issue stage: register the granted operands and pulse mul_en for one cycle.
  // The round-robin pointer moves only when a transfer happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_en     <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      r_issue_id <= '0;
      r_ptr      <= '0;
    end else begin
      mul_en <= w_xfer;
      if (w_xfer) begin
        mul_a      <= w_sel_a;
        mul_b      <= w_sel_b;
        r_issue_id <= w_gnt_id;
        r_ptr      <= w_ptr_nxt;
      end
    end
  end

  // Tag pipeline. It is loaded when the datapath samples mul_en and shifts
  // in lockstep with the datapath stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MUL_LAT; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      r_tag[0] <= '{valid: mul_en, id: r_issue_id};
      for (int k = 1; k < MUL_LAT; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  // Response stage: capture the product when a valid tag reaches the tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= w_tail.valid ? (NREQ'(1) << w_tail.id) : '0;
      if (w_tail.valid) begin
        rsp_data <= mul_res;
      end
    end
  end

  // Flush sequencing with a registered flush_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      flush_done <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          flush_done <= 1'b0;
          if (flush_req) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!busy) begin
            r_state    <= ST_DONE;
            flush_done <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!flush_req) begin
            r_state    <= ST_RUN;
            flush_done <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_RUN;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef RADIX8_SCHED_STATS_EN
  // Per-requester transfer counters. Each one wraps from 16'hFFFF to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          grant_cnt[16*i +: 16] <= grant_cnt[16*i +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_radix8_mul_scheduler.sv
// Bench for radix8_mul_scheduler. A behavioural datapath produces mul_res
// MUL_LAT cycles after it samples mul_en. Every accepted request is pushed to
// a scoreboard along with its expected product and due cycle. Every response
// is popped from the scoreboard and compared.
module tb_radix8_mul_scheduler;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*8-1:0] req_a = '0;
  logic [NREQ*8-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              flush_req = 1'b0;
  logic              flush_done;
  logic              mul_en;
  logic [7:0]        mul_a;
  logic [7:0]        mul_b;
  logic [15:0]       mul_res;
  logic [NREQ-1:0]   rsp_valid;
  logic [15:0]       rsp_data;
  logic              busy;
`ifdef RADIX8_SCHED_STATS_EN
  logic [NREQ*16-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  radix8_mul_scheduler #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .mul_en     (mul_en),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_res    (mul_res),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
`ifdef RADIX8_SCHED_STATS_EN
    .busy       (busy),
    .grant_cnt  (grant_cnt)
`else
    .busy       (busy)
`endif
  );

  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] ea;
    logic signed [15:0] eb;
    ea = {{8{a[7]}}, a};
    eb = {{8{b[7]}}, b};
    return ea * eb;
  endfunction

  // Behavioural datapath. When mul_en is not sampled, it shifts in a poison value.
  logic [15:0] dp [MUL_LAT];
  always @(posedge clk) begin
    dp[0] <= mul_en ? mul8(mul_a, mul_b) : 16'hDEAD;
    for (int k = 1; k < MUL_LAT; k++) dp[k] <= dp[k-1];
  end
  assign mul_res = dp[MUL_LAT-1];

  typedef struct {
    int          id;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   gnt_log[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   rsp_cnt = 0;
  int   acc_cnt = 0;
  exp_t acc_e;
  exp_t mon_e;
  logic [NREQ-1:0] mon_oh;

  // Acceptance monitor: samples the handshake before the edge updates state.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          acc_e.id   = i;
          acc_e.data = mul8(req_a[8*i +: 8], req_b[8*i +: 8]);
          acc_e.due  = cyc + MUL_LAT + 1;
          sb.push_back(acc_e);
          gnt_log.push_back(i);
          acc_cnt++;
        end
      end
    end
  end

  // Response monitor: owner, data and arrival cycle against the scoreboard.
  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: rsp_valid=%b rsp_data=%h, none expected", rsp_valid, rsp_data);
      end else begin
        mon_e = sb.pop_front();
        rsp_cnt++;
        mon_oh = '0;
        mon_oh[mon_e.id] = 1'b1;
        if (rsp_valid !== mon_oh) begin
          bad++;
          $display("FAIL rsp_owner: got %b want %b", rsp_valid, mon_oh);
        end
        total++;
        if (rsp_data !== mon_e.data) begin
          bad++;
          $display("FAIL rsp_data: got %h want %h (id %0d)", rsp_data, mon_e.data, mon_e.id);
        end
        total++;
        if (cyc !== mon_e.due) begin
          bad++;
          $display("FAIL rsp_latency: arrived cycle %0d want %0d", cyc, mon_e.due);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    flush_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    gnt_log.delete();
  endtask

  task automatic wait_idle;
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && busy === 1'b0 && rsp_valid === '0) begin
        idle = 1'b1;
        break;
      end
    end
    total++;
    if (!idle) begin
      bad++;
      $display("FAIL idle_timeout: pending=%0d busy=%b want pending=0 busy=0", sb.size(), busy);
    end
  endtask

  task automatic test_reset;
    do_reset();
    total++;
    if ({mul_en, flush_done, busy, rsp_valid, req_ready} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: mul_en=%b flush_done=%b busy=%b rsp_valid=%b req_ready=%b want all 0",
               mul_en, flush_done, busy, rsp_valid, req_ready);
    end
    total++;
    if ({mul_a, mul_b, rsp_data} !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: mul_a=%h mul_b=%h rsp_data=%h want 0", mul_a, mul_b, rsp_data);
    end
    // The pointer is 0 after reset, so the search starts at requester 0.
    req_valid = 4'b0010;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL arb_single: got %b want 0010", req_ready);
    end
    req_valid = 4'b1010;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL arb_prio: got %b want 0010", req_ready);
    end
    req_valid = 4'b1001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL arb_start0: got %b want 0001", req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_single;
    int acc;
    @(negedge clk);
    req_a[7:0] = 8'h80;
    req_b[7:0] = 8'h7F;
    req_valid  = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    @(negedge clk);
    acc = cyc;
    req_valid = '0;
    total++;
    if ({mul_en, mul_a, mul_b} !== {1'b1, 8'h80, 8'h7F}) begin
      bad++;
      $display("FAIL single_issue: mul_en=%b mul_a=%h mul_b=%h want 1 80 7f", mul_en, mul_a, mul_b);
    end
    @(negedge clk);
    total++;
    if (mul_en !== 1'b0) begin
      bad++;
      $display("FAIL single_pulse: mul_en=%b want 0", mul_en);
    end
    for (int k = 0; k < 20 && rsp_valid === '0; k++) @(negedge clk);
    total++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 16'hC080) begin
      bad++;
      $display("FAIL single_rsp: rsp_valid=%b rsp_data=%h want 0001 c080", rsp_valid, rsp_data);
    end
    total++;
    if (cyc - acc !== MUL_LAT + 1) begin
      bad++;
      $display("FAIL single_latency: edges after accept %0d want %0d", cyc - acc, MUL_LAT + 1);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back;
    int en_cnt;
    bit order_ok;
    do_reset();
    en_cnt = 0;
    req_a = $urandom();
    req_b = $urandom();
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mul_en === 1'b1) en_cnt++;
      req_a = $urandom();
      req_b = $urandom();
    end
    req_valid = '0;
    total++;
    if (en_cnt !== 8) begin
      bad++;
      $display("FAIL b2b_mul_en: high for %0d of 8 cycles want 8", en_cnt);
    end
    @(negedge clk);
    total++;
    if (mul_en !== 1'b0) begin
      bad++;
      $display("FAIL b2b_mul_en_end: mul_en=%b want 0", mul_en);
    end
    order_ok = (gnt_log.size() == 8);
    for (int k = 0; k < gnt_log.size() && k < 8; k++) begin
      if (gnt_log[k] != k % 4) order_ok = 1'b0;
    end
    total++;
    if (!order_ok) begin
      bad++;
      $display("FAIL b2b_order: got %0d grants, order %p want 0,1,2,3,0,1,2,3", gnt_log.size(), gnt_log);
    end
    wait_idle();
  endtask

  task automatic test_flush;
    int r0;
    bit leak;
    @(negedge clk);
    req_a[23:16] = 8'hF3;
    req_b[23:16] = 8'h25;
    req_valid = 4'b0100;
    @(negedge clk);
    req_a[23:16] = 8'h7F;
    req_b[23:16] = 8'h81;
    @(negedge clk);
    r0 = rsp_cnt;
    req_valid = 4'b1111;
    flush_req = 1'b1;
    #1;
    total++;
    if (req_ready !== '0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL flush_entry: req_ready=%b busy=%b want 0000 1", req_ready, busy);
    end
    leak = 1'b0;
    for (int k = 0; k < 40 && flush_done !== 1'b1; k++) begin
      @(negedge clk);
      if (req_ready !== '0) leak = 1'b1;
    end
    total++;
    if (leak) begin
      bad++;
      $display("FAIL flush_grant_leak: req_ready nonzero during drain, want 0000");
    end
    total++;
    if (flush_done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_done: flush_done=%b busy=%b want 1 0", flush_done, busy);
    end
    total++;
    if (rsp_cnt - r0 !== 2) begin
      bad++;
      $display("FAIL flush_drained: delivered %0d responses want 2", rsp_cnt - r0);
    end
    @(negedge clk);
    total++;
    if (flush_done !== 1'b1 || req_ready !== '0) begin
      bad++;
      $display("FAIL flush_hold: flush_done=%b req_ready=%b want 1 0000", flush_done, req_ready);
    end
    flush_req = 1'b0;
    @(negedge clk);
    total++;
    if (flush_done !== 1'b0 || !$onehot(req_ready)) begin
      bad++;
      $display("FAIL flush_resume: flush_done=%b req_ready=%b want 0 one-hot", flush_done, req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_idle();
  endtask

  task automatic test_reset_mid;
    bit leak;
    @(negedge clk);
    req_a[7:0] = 8'h11;
    req_b[7:0] = 8'h22;
    req_valid = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    req_valid = '0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_inflight: busy=%b want 1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    total++;
    if ({mul_en, flush_done, busy, rsp_valid, req_ready} !== '0 || {mul_a, mul_b, rsp_data} !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_outputs: mul_en=%b busy=%b rsp_valid=%b mul_a=%h mul_b=%h rsp_data=%h want all 0",
               mul_en, busy, rsp_valid, mul_a, mul_b, rsp_data);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    leak = 1'b0;
    for (int k = 0; k < 2 * MUL_LAT + 5; k++) begin
      @(negedge clk);
      if (rsp_valid !== '0) leak = 1'b1;
    end
    total++;
    if (leak) begin
      bad++;
      $display("FAIL rstmid_no_rsp: rsp_valid seen after reset want none");
    end
  endtask

  task automatic test_sweep;
    int a0;
    int j;
    a0 = acc_cnt;
    @(negedge clk);
    req_valid = 4'b0100;
    for (int i = 0; i < 512; i++) begin
      if (i < 256) begin
        req_a[23:16] = 8'(i) ^ 8'h80;
        req_b[23:16] = 8'(255 - i) ^ 8'h80;
      end else begin
        j = i - 256;
        req_b[23:16] = 8'(j) ^ 8'h80;
        req_a[23:16] = 8'(j * 73) ^ 8'h80;
      end
      @(negedge clk);
    end
    req_valid = '0;
    total++;
    if (acc_cnt - a0 !== 512) begin
      bad++;
      $display("FAIL sweep_accepts: got %0d want 512", acc_cnt - a0);
    end
    wait_idle();
  endtask

`ifdef RADIX8_SCHED_STATS_EN
  task automatic test_stats;
    do_reset();
    req_a[15:8] = 8'h03;
    req_b[15:8] = 8'hFD;
    req_valid = 4'b0010;
    repeat (3) @(negedge clk);
    req_valid = '0;
    total++;
    if (grant_cnt[31:16] !== 16'd3) begin
      bad++;
      $display("FAIL stats_req1: got %0d want 3", grant_cnt[31:16]);
    end
    total++;
    if ({grant_cnt[63:32], grant_cnt[15:0]} !== 48'h0) begin
      bad++;
      $display("FAIL stats_others: got %h want 0", {grant_cnt[63:32], grant_cnt[15:0]});
    end
    wait_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_sweep();
`ifdef RADIX8_SCHED_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
